// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch queue.
// fetch_entry_t is the {pc, instr} pair buffered between ROM and decode.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF   = 4;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of DEPTH entries with push/pop/flush; head registered, 1-cycle push-to-head latency.
// Push and pop may coincide at any occupancy; flush empties the buffer at the next edge.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_dat_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full_o   = (count_q == CW'(DEPTH));
    empty_o  = (count_q == '0);
    count_o  = count_q;
    head_o   = mem_q[rd_ptr_q];
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch: credit-limited sequential ROM reads into a FIFO, handshaked to decode; redirect flushes.
// Optional FETCH_BYPASS_EN presents a response straight to decode when the FIFO is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter int               INSTR_W  = INSTR_W_DEF,
  parameter int               DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_n,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_kill_q, pend_kill_d;

  entry_t        fifo_head, resp_ent, out_ent;
  logic [CW-1:0] fifo_count, occ;
  logic          fifo_full, fifo_empty;
  logic          issue, resp_vld, bypass, push, pop;

  always_comb begin
    // A same-cycle pop is deliberately not credited back to the issue check.
    occ            = fifo_count + CW'(pend_q);
    issue          = rstn && !redirect && (occ < CW'(DEPTH));
    resp_vld       = pend_q && !pend_kill_q && !redirect;
    resp_ent.pc    = pend_pc_q;
    resp_ent.instr = rom_data;
`ifdef FETCH_BYPASS_EN
    bypass  = fifo_empty && resp_vld;
    out_ent = bypass ? resp_ent : fifo_head;
`else
    bypass  = 1'b0;
    out_ent = fifo_head;
`endif
    out_valid = rstn && !redirect && (bypass || !fifo_empty);
    pop       = out_valid && out_ready && !fifo_empty;
    push      = resp_vld && !(bypass && out_ready);

    rom_en    = issue;
    rom_addr  = fetch_pc_q;
    out_pc    = out_ent.pc;
    out_pc_n  = out_ent.pc + ADDR_W'(INSTR_BYTES);
    out_instr = out_ent.instr;

    pend_d      = issue;
    pend_pc_d   = issue ? fetch_pc_q : pend_pc_q;
    pend_kill_d = redirect && pend_q;
    fetch_pc_d  = fetch_pc_q;
    if (redirect)   fetch_pc_d = redirect_pc;
    else if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc_q  <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= RESET_PC;
      pend_kill_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      pend_kill_q <= pend_kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i (resp_ent),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rstn && !redirect) assert (!(push && fifo_full && !pop));
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: ROM model returns word index, scoreboard holds expected pc order.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int IW    = 32;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rstn, redirect, rom_en, out_valid, out_ready;
  logic [AW-1:0] redirect_pc, rom_addr, out_pc, out_pc_n;
  logic [IW-1:0] rom_data, out_instr;

  int            errors = 0, checks = 0;
  int            n_iss = 0, n_acc = 0;
  logic [AW-1:0] sb [$];
  logic          s_en, s_vld;
  logic [AW-1:0] s_addr, s_pc;
  logic          wrap_seen = 1'b0;
  logic [AW-1:0] wrap_pn = '1;

  fetch_queue #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_pc_n    (out_pc_n),
    .out_instr   (out_instr)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: ROM[i] = i, garbage when not read so stale data is visible.
  always @(posedge clk) rom_data <= rom_en ? (rom_addr >> 2) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] p;
    p = start;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      sb.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // One clock: sample away from the edge, score any handshake, then advance.
  task automatic tick();
    logic [AW-1:0] e, en;
    @(negedge clk);
    s_en   = rom_en;
    s_addr = rom_addr;
    s_vld  = out_valid;
    s_pc   = out_pc;
    if (rom_en) n_iss++;
    if (out_valid && out_ready) begin
      n_acc++;
      chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        en = e + 32'd4;
        chk("out_pc", out_pc, e);
        chk("out_instr", out_instr, e >> 2);
        chk("out_pc_n", out_pc_n, en);
        if (e == 32'hFFFF_FFFC) begin
          wrap_seen = 1'b1;
          wrap_pn   = out_pc_n;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rstn        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = rdy;
    sb_load(32'h0, 1200);
    repeat (2) begin
      tick();
      chk("rst_rom_en", s_en, 0);
      chk("rst_out_valid", s_vld, 0);
    end
    rstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, bi, ba, occ, max_occ;

    // Streaming from reset with decode always ready.
    do_reset(1'b1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("stream_rom_en", s_en, 1);
      chk("stream_rom_addr", s_addr, 64'(4 * c));
      chk("stream_out_valid", s_vld, 64'(c >= LAT));
    end
    repeat (10) tick();

    // Backpressure: exactly DEPTH reads, then drain 0..12 in order.
    do_reset(1'b0);
    base = n_iss;
    repeat (12) tick();
    chk("bp_issue_count", 64'(n_iss - base), 4);
    chk("bp_rom_en_idle", s_en, 0);
    out_ready = 1'b1;
    base = n_acc;
    for (int i = 0; i < 40 && (n_acc - base) < 13; i++) tick();
    chk("bp_drain_count", 64'(n_acc - base), 13);

    // Redirect with 3 entries buffered and 1 read in flight.
    do_reset(1'b0);
    repeat (4) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    out_ready   = 1'b1;
    sb_load(32'h100, 64);
    tick();
    chk("redir_t_valid", s_vld, 0);
    chk("redir_t_rom_en", s_en, 0);
    redirect = 1'b0;
    tick();
    chk("redir_t1_valid", s_vld, 0);
    chk("redir_t1_rom_en", s_en, 1);
    chk("redir_t1_rom_addr", s_addr, 32'h100);
    tick();
    chk("redir_t2_valid", s_vld, 64'(LAT == 1));
    tick();
    chk("redir_t3_valid", s_vld, 1);
    chk("redir_t3_pc", s_pc, 32'h100);
    base = n_acc;
    repeat (8) tick();
    chk("redir_progress", 64'(n_acc - base), 8);

    // Back-to-back redirects: the last one wins.
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    sb_load(32'h200, 64);
    tick();
    redirect_pc = 32'h300;
    sb_load(32'h300, 64);
    tick();
    redirect = 1'b0;
    base = n_acc;
    repeat (8) tick();
    chk("b2b_progress", 64'(n_acc - base), 64'(8 - LAT));

    // Random decode backpressure against the occupancy bound.
    do_reset(1'b0);
    bi = n_iss;
    ba = n_acc;
    max_occ = 0;
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      occ = (n_iss - bi) - (n_acc - ba);
      if (occ > max_occ) max_occ = occ;
    end
    chk("rand_max_occ_le_depth", 64'(max_occ <= DEPTH), 1);
    chk("rand_progress", 64'((n_acc - ba) > 300), 1);

    // Reset mid-stream with the FIFO half full.
    do_reset(1'b0);
    repeat (3) tick();
    rstn      = 1'b0;
    out_ready = 1'b1;
    sb_load(32'h0, 64);
    tick();
    chk("mrst_valid0", s_vld, 0);
    tick();
    chk("mrst_valid1", s_vld, 0);
    chk("mrst_rom_en", s_en, 0);
    rstn = 1'b1;
    tick();
    chk("mrst_resume_en", s_en, 1);
    chk("mrst_resume_addr", s_addr, 32'h0);
    base = n_acc;
    repeat (6) tick();
    chk("mrst_progress", 64'(n_acc - base), 64'(7 - LAT));

    // Address wrap at the top of the pc space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    sb_load(32'hFFFF_FFF8, 16);
    tick();
    redirect = 1'b0;
    base = n_acc;
    tick();
    chk("wrap_addr_fff8", s_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr_fffc", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr_zero", s_addr, 32'h0);
    repeat (6) tick();
    chk("wrap_progress", 64'(n_acc - base), 64'(9 - LAT));
    chk("wrap_entry_seen", wrap_seen, 1);
    chk("wrap_pc_n_zero", wrap_pn, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
